// File: rtl/hs_axis_pkg.sv
// Shared definitions for the AXI4-Stream register slice: the slice state and the packed payload width.
// No logic, so latency and backpressure do not apply here.
package hs_axis_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Payload = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup}
    function automatic int payload_width(input int data_w, input int strb_w, input int keep_w,
                                         input int id_w, input int dest_w, input int user_w);
        return data_w + strb_w + keep_w + 1 + id_w + dest_w + user_w + 1;
    endfunction

endpackage

// File: rtl/hs_axis_proto_chk.sv
// Slave-side stream rule checker: valid must stay high and payload stable while stalled.
// Flags are sticky until reset and update one edge after the offending cycle; it never stalls the stream.
module hs_axis_proto_chk #(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             tvalid,
    input  logic             tready,
    input  logic [WIDTH-1:0] payload,
    output logic             err_hold,
    output logic             err_drop
);

    logic             stalled;
    logic [WIDTH-1:0] payload_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stalled   <= 1'b0;
            payload_q <= '0;
            err_hold  <= 1'b0;
            err_drop  <= 1'b0;
        end else begin
            // A beat offered but not taken last cycle must be re-offered unchanged
            if (stalled) begin
                if (!tvalid)
                    err_drop <= 1'b1;
                if (payload != payload_q)
                    err_hold <= 1'b1;
            end
            stalled   <= tvalid & ~tready;
            payload_q <= payload;
        end
    end

endmodule

// File: rtl/hs_axis_modport_slice.sv
// Full-throughput AXI4-Stream register slice with a two-entry skid buffer and slave-side rule checking.
// One cycle latency; s_tready is registered and drops only when both entries are occupied.
module hs_axis_modport_slice
    import hs_axis_pkg::*;
#(
    parameter int TDATA_WIDTH = 8,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int TSTRB_WIDTH = TDATA_WIDTH / 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_tvalid,
    input  logic [TDATA_WIDTH-1:0] s_tdata,
    input  logic [TSTRB_WIDTH-1:0] s_tstrb,
    input  logic [TKEEP_WIDTH-1:0] s_tkeep,
    input  logic                   s_tlast,
    input  logic [TID_WIDTH-1:0]   s_tid,
    input  logic [TDEST_WIDTH-1:0] s_tdest,
    input  logic [TUSER_WIDTH-1:0] s_tuser,
    input  logic                   s_twakeup,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [TDATA_WIDTH-1:0] m_tdata,
    output logic [TSTRB_WIDTH-1:0] m_tstrb,
    output logic [TKEEP_WIDTH-1:0] m_tkeep,
    output logic                   m_tlast,
    output logic [TID_WIDTH-1:0]   m_tid,
    output logic [TDEST_WIDTH-1:0] m_tdest,
    output logic [TUSER_WIDTH-1:0] m_tuser,
    output logic                   m_twakeup,
    input  logic                   m_tready,
    output logic                   err_hold,
    output logic                   err_drop
);

    localparam int PW = payload_width(TDATA_WIDTH, TSTRB_WIDTH, TKEEP_WIDTH,
                                      TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH);

    logic [PW-1:0] s_payload;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    state_e        state_q;
    state_e        state_d;
    logic          accept;
    logic          load_main_in;
    logic          load_main_skid;
    logic          load_skid;

    assign s_payload = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser, s_twakeup};
    assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser, m_twakeup} = main_q;

    assign accept = s_tvalid & s_tready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (accept && m_tready) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (m_tready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (m_tready) begin
                    load_main_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs are registered from the next state so neither port sees a combinational path
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= EMPTY;
            s_tready <= 1'b0;
            m_tvalid <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state_q  <= state_d;
            s_tready <= (state_d != FULL);
            m_tvalid <= (state_d != EMPTY);
            if (load_main_in)
                main_q <= s_payload;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= s_payload;
        end
    end

    hs_axis_proto_chk #(
        .WIDTH (PW)
    ) u_chk (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .tvalid   (s_tvalid),
        .tready   (s_tready),
        .payload  (s_payload),
        .err_hold (err_hold),
        .err_drop (err_drop)
    );

endmodule

// File: tb/tb_hs_axis_modport_slice.sv
// Directed bench for hs_axis_modport_slice: reset, streaming, backpressure, sideband, rule flags, mid-reset.
module tb_hs_axis_modport_slice;

    logic       aclk;
    logic       aresetn;
    logic       s_tvalid;
    logic [7:0] s_tdata;
    logic       s_tstrb;
    logic       s_tkeep;
    logic       s_tlast;
    logic       s_tid;
    logic       s_tdest;
    logic       s_tuser;
    logic       s_twakeup;
    logic       s_tready;
    logic       m_tvalid;
    logic [7:0] m_tdata;
    logic       m_tstrb;
    logic       m_tkeep;
    logic       m_tlast;
    logic       m_tid;
    logic       m_tdest;
    logic       m_tuser;
    logic       m_twakeup;
    logic       m_tready;
    logic       err_hold;
    logic       err_drop;

    int passed = 0;
    int total  = 0;

    hs_axis_modport_slice dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_tvalid  (s_tvalid),
        .s_tdata   (s_tdata),
        .s_tstrb   (s_tstrb),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .s_tid     (s_tid),
        .s_tdest   (s_tdest),
        .s_tuser   (s_tuser),
        .s_twakeup (s_twakeup),
        .s_tready  (s_tready),
        .m_tvalid  (m_tvalid),
        .m_tdata   (m_tdata),
        .m_tstrb   (m_tstrb),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .m_tid     (m_tid),
        .m_tdest   (m_tdest),
        .m_tuser   (m_tuser),
        .m_twakeup (m_twakeup),
        .m_tready  (m_tready),
        .err_hold  (err_hold),
        .err_drop  (err_drop)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic beat(input logic vld, input logic [7:0] dat, input logic last);
        s_tvalid = vld;
        s_tdata  = dat;
        s_tlast  = last;
    endtask

    initial begin
        aresetn   = 1'b0;
        m_tready  = 1'b0;
        s_tstrb   = 1'b0;
        s_tkeep   = 1'b0;
        s_tid     = 1'b0;
        s_tdest   = 1'b0;
        s_tuser   = 1'b0;
        s_twakeup = 1'b0;
        beat(1'b0, 8'h00, 1'b0);

        // Reset state and release
        tick();
        tick();
        chk1("rst_m_tvalid", m_tvalid, 1'b0);
        chk1("rst_s_tready", s_tready, 1'b0);
        chk1("rst_err_hold", err_hold, 1'b0);
        chk1("rst_err_drop", err_drop, 1'b0);
        chk8("rst_m_tdata", m_tdata, 8'h00);
        aresetn = 1'b1;
        #2;
        chk1("rel_s_tready_low", s_tready, 1'b0);
        tick();
        chk1("rel_s_tready_high", s_tready, 1'b1);
        chk1("rel_m_tvalid", m_tvalid, 1'b0);

        // Streaming 0x01..0x10, one beat per cycle
        m_tready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            beat(1'b1, 8'(i), i == 16);
            tick();
            chk1("stream_vld", m_tvalid, 1'b1);
            chk8("stream_dat", m_tdata, 8'(i));
            chk1("stream_last", m_tlast, i == 16);
            chk1("stream_rdy", s_tready, 1'b1);
        end
        beat(1'b0, 8'h00, 1'b0);
        tick();
        chk1("stream_drain", m_tvalid, 1'b0);

        // Backpressure: one extra beat absorbed, then s_tready drops
        m_tready = 1'b0;
        beat(1'b1, 8'hA1, 1'b0);
        tick();
        chk8("bp_a1", m_tdata, 8'hA1);
        chk1("bp_rdy_one", s_tready, 1'b1);
        beat(1'b1, 8'hA2, 1'b0);
        tick();
        chk8("bp_hold_a1", m_tdata, 8'hA1);
        chk1("bp_rdy_full", s_tready, 1'b0);
        beat(1'b1, 8'hA3, 1'b0);
        tick();
        chk8("bp_hold_a1_2", m_tdata, 8'hA1);
        chk1("bp_vld_hold", m_tvalid, 1'b1);
        chk1("bp_rdy_full_2", s_tready, 1'b0);
        m_tready = 1'b1;
        tick();
        chk8("bp_out_a2", m_tdata, 8'hA2);
        chk1("bp_rdy_back", s_tready, 1'b1);
        tick();
        chk8("bp_out_a3", m_tdata, 8'hA3);
        beat(1'b0, 8'h00, 1'b0);
        tick();
        chk1("bp_drain", m_tvalid, 1'b0);
        chk1("bp_no_hold_err", err_hold, 1'b0);
        chk1("bp_no_drop_err", err_drop, 1'b0);

        // Sideband fields pass through bit-exact
        s_tid = 1'b1; s_tdest = 1'b1; s_tuser = 1'b1;
        s_tkeep = 1'b1; s_tstrb = 1'b0; s_twakeup = 1'b1;
        beat(1'b1, 8'h3C, 1'b1);
        tick();
        chk8("sb_dat", m_tdata, 8'h3C);
        chk1("sb_tid", m_tid, 1'b1);
        chk1("sb_tdest", m_tdest, 1'b1);
        chk1("sb_tuser", m_tuser, 1'b1);
        chk1("sb_tkeep", m_tkeep, 1'b1);
        chk1("sb_tstrb", m_tstrb, 1'b0);
        chk1("sb_twakeup", m_twakeup, 1'b1);
        chk1("sb_tlast", m_tlast, 1'b1);
        s_tid = 1'b0; s_tdest = 1'b0; s_tuser = 1'b0; s_tkeep = 1'b0; s_twakeup = 1'b0;
        beat(1'b0, 8'h00, 1'b0);
        tick();
        chk1("sb_drain", m_tvalid, 1'b0);

        // Rule violations while stalled
        m_tready = 1'b0;
        beat(1'b1, 8'h11, 1'b0);
        tick();
        beat(1'b1, 8'h22, 1'b0);
        tick();
        chk1("viol_full", s_tready, 1'b0);
        beat(1'b1, 8'h55, 1'b0);
        tick();
        chk1("viol_hold_clean", err_hold, 1'b0);
        beat(1'b1, 8'h66, 1'b0);
        tick();
        chk1("viol_hold_set", err_hold, 1'b1);
        chk1("viol_drop_clean", err_drop, 1'b0);
        chk8("viol_dp_untouched", m_tdata, 8'h11);
        tick();
        chk1("viol_hold_sticky", err_hold, 1'b1);
        beat(1'b0, 8'h66, 1'b0);
        tick();
        chk1("viol_drop_set", err_drop, 1'b1);
        m_tready = 1'b1;
        tick();
        chk8("viol_out_22", m_tdata, 8'h22);
        tick();
        chk1("viol_drain", m_tvalid, 1'b0);
        chk1("viol_drop_sticky", err_drop, 1'b1);
        chk1("viol_hold_sticky_2", err_hold, 1'b1);

        // Mid-transfer reset from FULL
        m_tready = 1'b0;
        beat(1'b1, 8'hB1, 1'b0);
        tick();
        beat(1'b1, 8'hB2, 1'b0);
        tick();
        chk1("mr_full_rdy", s_tready, 1'b0);
        chk1("mr_full_vld", m_tvalid, 1'b1);
        beat(1'b0, 8'h00, 1'b0);
        aresetn = 1'b0;
        #1;
        chk1("mr_vld_async", m_tvalid, 1'b0);
        chk1("mr_rdy_async", s_tready, 1'b0);
        chk1("mr_hold_clr", err_hold, 1'b0);
        chk1("mr_drop_clr", err_drop, 1'b0);
        chk8("mr_dat_clr", m_tdata, 8'h00);
        tick();
        aresetn  = 1'b1;
        m_tready = 1'b1;
        tick();
        chk1("mr_rdy_back", s_tready, 1'b1);
        chk1("mr_no_stale_1", m_tvalid, 1'b0);
        tick();
        chk1("mr_no_stale_2", m_tvalid, 1'b0);
        beat(1'b1, 8'hC1, 1'b0);
        tick();
        chk1("mr_new_vld", m_tvalid, 1'b1);
        chk8("mr_new_dat", m_tdata, 8'hC1);
        beat(1'b0, 8'h00, 1'b0);
        tick();
        chk1("mr_new_drain", m_tvalid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hs_axis_modport_slice.md
# hs_axis_modport_slice

Full-throughput AXI4-Stream register slice that sits between a slave-side stream and a master-side stream. It breaks the combinational path on both the payload/valid path and the tready path using a two-entry skid buffer, and forwards every sideband field unchanged. It also monitors the slave-side handshake for the two protocol rules enforced on the codebase's AXI-Stream interface and raises sticky error flags when either rule is violated.

## Interface
- TDATA_WIDTH, 8: tdata width in bits (multiple of 8)
- TID_WIDTH, 1: tid width
- TDEST_WIDTH, 1: tdest width
- TUSER_WIDTH, 1: tuser width
- TKEEP_WIDTH, TDATA_WIDTH/8: tkeep width
- TSTRB_WIDTH, TDATA_WIDTH/8: tstrb width

Ports:
- aclk  in  1  the block's single clock; all logic is on the rising edge
- aresetn  in  1  asynchronous, active-low reset
- s_tvalid, s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser, s_twakeup  in  per parameter (1 for scalars)  upstream stream
- s_tready  out  1  upstream ready
- m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser, m_twakeup  out  per parameter  downstream stream
- m_tready  in  1  downstream ready
- err_hold  out  1  sticky: slave payload changed while stalled
- err_drop  out  1  sticky: s_tvalid dropped before handshake

## Operation
- Payload = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup}; moved as one word, bit-exact, never modified.
- Two registers: main (drives m_*) and skid. State: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
- EMPTY: an accepted input loads main -> ONE.
- ONE: accept with m_tready=1 -> reload main, stay ONE; accept with m_tready=0 -> load skid -> FULL; no accept with m_tready=1 -> EMPTY.
- FULL: s_tready=0; m_tready=1 moves skid to main -> ONE.
- Ordering is strict FIFO; no beat is duplicated or lost.
- Checker, evaluated on slave port while aresetn=1: if s_tvalid=1 and s_tready=0 in cycle N, then in cycle N+1 s_tvalid must be 1 (else err_drop<=1) and every payload field must equal its cycle-N value (else err_hold<=1). Flags stay set until reset. Violations never alter the data path; the datapath has already captured nothing from a stalled slave.

## Timing
- Reset: m_tvalid=0, s_tready=0, err_hold=0, err_drop=0; m_* payload registers reset to 0.
- s_tready rises on the first aclk edge after aresetn deasserts; it is a register output (no combinational path from m_tready).
- m_tvalid and m_* payload are register outputs.
- Latency: a beat accepted at edge N is presented on m_* after edge N (visible in cycle N+1).
- Throughput: one beat per cycle when m_tready stays 1.
- s_tready deasserts only in FULL; at most one extra beat is absorbed after m_tready falls.
- Reset mid-transfer: both entries are discarded, state to EMPTY immediately (asynchronous); error flags cleared.
- m_* payload holds stable while m_tvalid=1 and m_tready=0; m_tvalid never drops before handshake.

## Structure
- Shared package hs_axis_pkg: state enum (EMPTY, ONE, FULL) and a constant function returning the packed payload width from the six parameters.
- One sub-module, hs_axis_proto_chk: the slave-side rule checker producing err_hold/err_drop, reusable on any stream port.
- Top module holds skid registers, state machine, and payload pack/unpack.

## Test plan
- Reset release: aresetn 0->1 -> s_tready 0 for one cycle then 1; m_tvalid 0; flags 0.
- Streaming: m_tready=1, send tdata 0x01..0x10 back-to-back with tlast on 0x10 -> same 16 beats out, one cycle later each, tlast only on 0x10, no bubbles.
- Backpressure: m_tready=0 while sending 0xA1,0xA2,0xA3 -> m_tdata holds 0xA1, s_tready falls after 0xA2 accepted; release m_tready -> out order 0xA1,0xA2,0xA3.
- Sideband: beat with tid=1, tdest=1, tuser=1, tkeep=1, tstrb=0, twakeup=1 -> identical values on m_*.
- Violations: stall (s_tready=0) and change s_tdata 0x55->0x66 -> err_hold=1, stays 1; separately drop s_tvalid while stalled -> err_drop=1.
- Mid-reset: FULL with 0xB1,0xB2, assert aresetn=0 -> m_tvalid=0 immediately; after release no stale beat emerges.
